// File: rtl/multi_channel_pulse_gen.sv
// Collects one operand per producer over dav_/rfd handshakes, reduces them (max/min/sum)
// and emits a single pulse on out lasting that many clock periods.
module multi_channel_pulse_gen #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   dav_,
    output logic [N-1:0]   rfd,
    input  logic [N*W-1:0] data,
    input  logic [1:0]     mode,
    output logic           out,
    output logic           busy
);

    localparam int RW = W + $clog2(N);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] PULSE   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  op [N];
    logic [N-1:0]  got;
    logic [RW-1:0] counter;
    logic [RW-1:0] result;
    logic [RW-1:0] max_val;
    logic [RW-1:0] min_val;
    logic [RW-1:0] sum_val;

    // Operands are zero-extended to RW so the sum of N operands cannot wrap.
    always_comb begin
        max_val = RW'(op[0]);
        min_val = RW'(op[0]);
        sum_val = '0;
        for (int i = 0; i < N; i++) begin
            if (RW'(op[i]) > max_val) max_val = RW'(op[i]);
            if (RW'(op[i]) < min_val) min_val = RW'(op[i]);
            sum_val = sum_val + RW'(op[i]);
        end
        case (mode)
            2'b01:   result = min_val;
            2'b10:   result = sum_val;
            default: result = max_val;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= COLLECT;
            rfd     <= '1;
            got     <= '0;
            counter <= '0;
            out     <= 1'b0;
            for (int i = 0; i < N; i++) op[i] <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    // Each channel runs its own IDLE -> ACK -> HELD handshake.
                    for (int i = 0; i < N; i++) begin
                        if (rfd[i] && !dav_[i]) begin
                            op[i]  <= data[i*W +: W];
                            rfd[i] <= 1'b0;
                        end else if (!rfd[i] && !got[i] && dav_[i]) begin
                            got[i] <= 1'b1;
                        end
                    end
                    if (&got) state <= CALC;
                end
                CALC: begin
                    if (result != '0) begin
                        counter <= result;
                        out     <= 1'b1;
                        state   <= PULSE;
                    end else begin
                        state <= RELEASE;
                    end
                end
                PULSE: begin
                    counter <= counter - RW'(1);
                    if (counter == RW'(1)) begin
                        out   <= 1'b0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    got   <= '0;
                    rfd   <= '1;
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign busy = (state != COLLECT) || (|got) || !(&rfd);

endmodule

// File: tb/tb_multi_channel_pulse_gen.sv
// Drives an N=2 and an N=3 pulse generator with directed and randomized producer rounds
// and compares every cycle against a timeline model of the expected outputs.
module tb_multi_channel_pulse_gen;

    logic        clock;
    logic        reset;
    logic [1:0]  dav2;
    logic [1:0]  rfd2;
    logic [15:0] data2;
    logic [1:0]  mode2;
    logic        out2;
    logic        busy2;
    logic [2:0]  dav3;
    logic [2:0]  rfd3;
    logic [23:0] data3;
    logic [1:0]  mode3;
    logic        out3;
    logic        busy3;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    int  high_cnt [2];
    bit  cmp_on   = 0;
    bit  jitter   = 0;

    // Timeline model: per instance, the edge at which collection completed and the
    // reduced result; everything after that follows from plain arithmetic on edge numbers.
    logic [2:0] m_rfd  [2];
    logic [2:0] m_got  [2];
    int         m_op   [2][3];
    int         m_done [2];
    int         m_r    [2];
    logic       exp_out  [2];
    logic [2:0] exp_rfd  [2];
    logic       exp_busy [2];

    multi_channel_pulse_gen #(.N(2), .W(8)) dut2 (
        .clock (clock),
        .reset (reset),
        .dav_  (dav2),
        .rfd   (rfd2),
        .data  (data2),
        .mode  (mode2),
        .out   (out2),
        .busy  (busy2)
    );

    multi_channel_pulse_gen #(.N(3), .W(8)) dut3 (
        .clock (clock),
        .reset (reset),
        .dav_  (dav3),
        .rfd   (rfd3),
        .data  (data3),
        .mode  (mode3),
        .out   (out3),
        .busy  (busy3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic modelStep(input int u, input int n, input logic [2:0] dav,
                             input logic [23:0] dat, input logic [1:0] md);
        bit all;
        int mx, mn, sm;
        if (reset) begin
            m_rfd[u]  = 3'b111;
            m_got[u]  = 3'b000;
            m_done[u] = -1;
            m_r[u]    = 0;
            for (int i = 0; i < 3; i++) m_op[u][i] = 0;
        end else if (m_done[u] < 0) begin
            for (int i = 0; i < n; i++) begin
                if (m_rfd[u][i] && !dav[i]) begin
                    m_op[u][i]  = int'(dat[i*8 +: 8]);
                    m_rfd[u][i] = 1'b0;
                end else if (!m_rfd[u][i] && !m_got[u][i] && dav[i]) begin
                    m_got[u][i] = 1'b1;
                end
            end
            all = 1;
            for (int i = 0; i < n; i++) if (!m_got[u][i]) all = 0;
            if (all) m_done[u] = cyc;
        end else if (cyc == m_done[u] + 2) begin
            mx = m_op[u][0];
            mn = m_op[u][0];
            sm = 0;
            for (int i = 0; i < n; i++) begin
                if (m_op[u][i] > mx) mx = m_op[u][i];
                if (m_op[u][i] < mn) mn = m_op[u][i];
                sm += m_op[u][i];
            end
            m_r[u] = (md == 2'b01) ? mn : (md == 2'b10) ? sm : mx;
        end else if (cyc == m_done[u] + 3 + m_r[u]) begin
            m_rfd[u]  = 3'b111;
            m_got[u]  = 3'b000;
            m_done[u] = -1;
        end
        exp_out[u] = (m_done[u] >= 0) && (cyc >= m_done[u] + 2) && (cyc < m_done[u] + 2 + m_r[u]);
        exp_rfd[u] = m_rfd[u];
        exp_busy[u] = (u == 0) ? !(&m_rfd[u][1:0]) : !(&m_rfd[u]);
    endtask

    always @(posedge clock) begin
        cyc++;
        modelStep(0, 2, {1'b1, dav2}, {8'h00, data2}, mode2);
        modelStep(1, 3, dav3, data3, mode3);
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            checkOutput("rfd_n2",  int'(rfd2),  int'(exp_rfd[0][1:0]));
            checkOutput("out_n2",  int'(out2),  int'(exp_out[0]));
            checkOutput("busy_n2", int'(busy2), int'(exp_busy[0]));
            checkOutput("rfd_n3",  int'(rfd3),  int'(exp_rfd[1]));
            checkOutput("out_n3",  int'(out3),  int'(exp_out[1]));
            checkOutput("busy_n3", int'(busy3), int'(exp_busy[1]));
        end
        if (out2) high_cnt[0]++;
        if (out3) high_cnt[1]++;
        if (jitter) mode3 = 2'($urandom_range(0, 3));
    end

    function automatic logic [2:0] curRfd(input int u);
        return (u == 0) ? {1'b1, rfd2} : rfd3;
    endfunction

    function automatic logic curOut(input int u);
        return (u == 0) ? out2 : out3;
    endfunction

    task automatic setChan(input int u, input int i, input logic dv, input logic [7:0] v);
        if (u == 0) begin
            if (i == 0) begin dav2[0] = dv; data2[7:0]  = v; end
            else        begin dav2[1] = dv; data2[15:8] = v; end
        end else begin
            dav3[i] = dv;
            data3[i*8 +: 8] = v;
        end
    endtask

    // Producers in mask wait their delay, hold dav_ low until captured, then release
    // it and scramble their data bus so later changes must be ignored.
    task automatic applyStimulus(input int u, input int n, input logic [2:0] mask,
                                 input logic [23:0] vals, input int d0, input int d1,
                                 input int d2, input logic [1:0] md);
        int   phase [3];
        int   delay [3];
        logic seen  [3];
        logic [2:0] r;
        int   cnt;
        bit   done;
        delay = '{d0, d1, d2};
        for (int i = 0; i < 3; i++) begin
            phase[i] = (i < n && mask[i]) ? 0 : 2;
            seen[i]  = 1'b0;
        end
        if (u == 0) mode2 = md; else mode3 = md;
        cnt  = 0;
        done = 0;
        while (!done && cnt < 500) begin
            @(negedge clock);
            r = curRfd(u);
            for (int i = 0; i < 3; i++) begin
                if (phase[i] == 0 && cnt >= delay[i]) begin
                    setChan(u, i, 1'b0, vals[i*8 +: 8]);
                    seen[i]  = r[i];
                    phase[i] = 1;
                end else if (phase[i] == 1) begin
                    if (seen[i] && !r[i]) begin
                        setChan(u, i, 1'b1, 8'($urandom_range(0, 255)));
                        phase[i] = 2;
                    end else if (r[i]) begin
                        seen[i] = 1'b1;
                    end
                end
            end
            cnt++;
            done = (phase[0] == 2) && (phase[1] == 2) && (phase[2] == 2);
        end
        if (!done) checkOutput("handshake_timeout", cnt, -1);
    endtask

    task automatic waitIdle(input int u, input int budget);
        int   cnt;
        logic prev;
        prev = curOut(u);
        cnt  = 0;
        while (cnt < budget) begin
            @(negedge clock);
            if (curRfd(u) == 3'b111 && !curOut(u)) break;
            prev = curOut(u);
            cnt++;
        end
        if (cnt >= budget) checkOutput("idle_timeout", cnt, -1);
        else checkOutput("rfd_after_fall", int'(prev), 0);
    endtask

    task automatic runRound(input int u, input int n, input logic [23:0] vals,
                            input int d0, input int d1, input int d2,
                            input logic [1:0] md, input string name, input int expect_len);
        high_cnt[u] = 0;
        applyStimulus(u, n, 3'b111, vals, d0, d1, d2, md);
        waitIdle(u, 1000);
        if (expect_len >= 0) checkOutput(name, high_cnt[u], expect_len);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int x, y, z, cnt;
        reset = 1'b1;
        dav2  = 2'b11;
        dav3  = 3'b111;
        data2 = '0;
        data3 = '0;
        mode2 = 2'b00;
        mode3 = 2'b00;
        high_cnt[0] = 0;
        high_cnt[1] = 0;
        for (int u = 0; u < 2; u++) begin
            m_done[u] = -1;
            m_r[u]    = 0;
        end

        @(negedge clock);
        cmp_on = 1;
        checkOutput("reset_rfd",  int'(rfd2),  3);
        checkOutput("reset_out",  int'(out2),  0);
        checkOutput("reset_busy", int'(busy2), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        runRound(0, 2, {8'd0, 8'd25, 8'd12}, 0, 6, 0, 2'b00, "max_12_25", 25);
        runRound(0, 2, {8'd0, 8'd25, 8'd12}, 0, 6, 0, 2'b01, "min_12_25", 12);
        runRound(0, 2, {8'd0, 8'd25, 8'd12}, 3, 0, 0, 2'b10, "sum_12_25", 37);
        runRound(0, 2, {8'd0, 8'd255, 8'd255}, 0, 0, 0, 2'b10, "sum_255_255", 510);
        runRound(0, 2, {8'd0, 8'd200, 8'd9}, 0, 2, 0, 2'b11, "mode11_max", 200);

        // Zero result: no pulse, release three edges after the last dav_ is seen high.
        high_cnt[0] = 0;
        applyStimulus(0, 2, 3'b111, {8'd0, 8'd40, 8'd0}, 0, 3, 0, 2'b01);
        repeat (3) @(negedge clock);
        checkOutput("zero_rfd_held", int'(rfd2), 0);
        @(negedge clock);
        checkOutput("zero_rfd_release", int'(rfd2), 3);
        checkOutput("zero_busy", int'(busy2), 0);
        checkOutput("zero_no_pulse", high_cnt[0], 0);

        // Reset in the middle of a pulse.
        applyStimulus(0, 2, 3'b111, {8'd0, 8'd50, 8'd100}, 0, 0, 0, 2'b00);
        cnt = 0;
        while (!out2 && cnt < 20) begin @(negedge clock); cnt++; end
        checkOutput("pulse_started", int'(out2), 1);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midpulse_reset_out", int'(out2), 0);
        checkOutput("midpulse_reset_rfd", int'(rfd2), 3);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // N=3 simultaneous delivery, then an early producer on channel 0 during the pulse.
        high_cnt[1] = 0;
        applyStimulus(1, 3, 3'b111, {8'd17, 8'd30, 8'd5}, 0, 0, 0, 2'b00);
        cnt = 0;
        while (!out3 && cnt < 20) begin @(negedge clock); cnt++; end
        setChan(1, 0, 1'b0, 8'd9);
        waitIdle(1, 1000);
        checkOutput("n3_max_30", high_cnt[1], 30);
        high_cnt[1] = 0;
        @(negedge clock);
        checkOutput("early_capture", int'(rfd3), 3'b110);
        setChan(1, 0, 1'b1, 8'hEE);
        applyStimulus(1, 3, 3'b110, {8'd4, 8'd3, 8'd0}, 0, 1, 2, 2'b00);
        waitIdle(1, 1000);
        checkOutput("early_data_kept", high_cnt[1], 9);

        for (int k = 0; k < 32; k++) begin
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            runRound(0, 2, {8'd0, 8'(y), 8'(x)}, $urandom_range(0, 8), $urandom_range(0, 8),
                     0, 2'b00, "random_max", (x > y) ? x : y);
        end

        jitter = 1;
        for (int k = 0; k < 8; k++) begin
            x = $urandom_range(0, 120);
            y = $urandom_range(0, 120);
            z = $urandom_range(0, 120);
            runRound(1, 3, {8'(z), 8'(y), 8'(x)}, $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 5), 2'b00, "jitter_round", -1);
        end
        jitter = 0;
        repeat (3) @(negedge clock);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_pulse_gen.md
Name: multi_channel_pulse_gen

Overview:
- Collects one W-bit operand from each of N independent producers over dav_/rfd handshakes.
- Combines the operands using a selectable reduction: max, min or sum.
- Emits one pulse on out whose length in clock periods equals the reduced result.
- Next generation of the two-channel max-pulse unit, generalised in channel count, operand width and reduction mode; used wherever a measured-duration strobe is needed from several data sources.

Parameters:
N, 2, number of producer channels (N >= 2)
W, 8, operand width in bits
RW, W+$clog2(N), result and pulse-counter width (fixed by W and N, not overridable)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
dav_  input  N  per-channel data-valid, active-low; bit i belongs to channel i
rfd  output  N  per-channel ready-for-data, active-high
data  input  N*W  flattened operands; channel i on data[i*W +: W]
mode  input  2  reduction select: 00 max, 01 min, 10 sum, 11 treated as max
out  output  1  result pulse, active-high
busy  output  1  high from the first operand captured until the end of the pulse

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset: on any edge with reset=1, the block enters COLLECT.
  - rfd = all ones, out = 0, busy = 0.
  - All latched operands cleared, per-channel flags cleared, counter = 0.
  - Reset overrides every state, including mid-pulse: out falls at that edge.
- Per-channel handshake (channel i, independent of the others):
  - IDLE (rfd[i]=1): at an edge where dav_[i]=0, latch data[i] into op[i] and set rfd[i]=0; go to ACK.
  - ACK (rfd[i]=0): wait for dav_[i]=1, then set flag got[i]=1 and go to HELD.
  - HELD (rfd[i]=0): ignore dav_[i] and data[i] until the global release.
  - Data must be stable when dav_ falls; it is captured at that edge only.
  - Channels complete in any order; simultaneous completions are allowed.
- Global FSM:
  - COLLECT: busy=1 once any got[i] or rfd[i]=0. When all got[i]=1, go to CALC at the next edge.
  - CALC (1 cycle): sample mode and compute R (RW bits).
    - max: largest op.
    - min: smallest op.
    - sum: zero-extended sum of all op, which cannot overflow RW.
  - CALC, R > 0: load counter=R, set out=1, go to PULSE.
  - CALC, R = 0: no pulse; go directly to RELEASE.
  - PULSE: out=1; decrement the counter each edge. At the edge where the counter reaches 0, out=0; go to RELEASE.
  - Result: out is high for exactly R clock periods, rising edge to falling edge.
  - RELEASE (1 cycle): clear got[], set rfd = all ones, busy=0; go to COLLECT.
- Latency: the pulse rises 2 edges after the edge at which the last channel's dav_ is seen high.
- Early producer: a producer may assert dav_ for the next item while rfd is low. It is not accepted until rfd returns to 1, and no data is lost.
- mode changes outside CALC have no effect.
- Operand value 0 is legal in every mode.

Test Plan:
- Reset with N=2 → rfd=2'b11, out=0, busy=0; a 3-cycle reset pulse asserted mid-PULSE drops out at the first reset edge and rfd returns to 11.
- N=2, W=8, mode=00; x=12 (channel 0) and y=25 (channel 1) delivered with channel 1 arriving 6 cycles later → out high for exactly 25 periods; rfd rises only after the fall of out.
- Same operands with mode=01 → pulse of 12 periods; with mode=10 → 37 periods. Also x=255, y=255, mode=10 → 510 periods, confirming the RW=9 bits do not overflow.
- mode=01 with x=0, y=40 → no pulse; rfd returns to 11 three edges after the last dav_ release; busy drops.
- N=3 with 5, 30, 17 delivered simultaneously, mode=00 → 30-period pulse. Channel 0 re-asserting dav_ during PULSE is ignored until RELEASE, then captured.
- 32 back-to-back rounds with the randomized producer delays from the current bench pattern, mode=00, operands taken from the existing test-case generator → every pulse length equals max(x,y).
